// File: rtl/result_pkg.sv
// Shared types and constants for the result collector.
//   DEF_DATA_W / DEF_SEQ_W : default result and sequence-tag widths
//   STAT_SUM_W             : width of the wrapping running sum
//   result_entry_t         : one FIFO entry, {seq, data}
package result_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_SEQ_W  = 8;
    localparam int STAT_SUM_W = 16;

    typedef struct packed {
        logic [DEF_SEQ_W-1:0]  seq;
        logic [DEF_DATA_W-1:0] data;
    } result_entry_t;

endpackage

// File: rtl/result_fifo.sv
// First-word-fall-through FIFO with push/pop arbitration.
//   clk, rst    : clock, synchronous active-high reset
//   push_req_i  : new entry offered on din_i
//   pop_req_i   : consumer ready; pops only when the head is valid
//   dout_o      : head entry, combinational from storage
//   valid_o     : head is valid (not empty)
//   level_o     : occupancy, full_o / empty_o derived from it
//   drop_o      : offered entry discarded because full with no pop
module result_fifo
    import result_pkg::*;
#(
    parameter int  DEPTH   = 8,
    parameter type entry_t = result_entry_t,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int LVL_W   = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_req_i,
    input  entry_t           din_i,
    input  logic             pop_req_i,
    output entry_t           dout_o,
    output logic             valid_o,
    output logic [LVL_W-1:0] level_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             drop_o
);

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              push, pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign valid_o = !empty_o;
    assign level_o = level_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // A pop at the same edge frees a slot, so a push into a full FIFO is taken.
    assign pop    = valid_o && pop_req_i;
    assign push   = push_req_i && (!full_o || pop);
    assign drop_o = push_req_i && full_o && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: entries are only visible through a valid head.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/result_collector.sv
// Collects the W result stream: tags each result with a sequence number,
// buffers it in a FIFO drained over valid/ready, and keeps running stats.
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/in_data: one-cycle result strobe and value
//   stats_clr       : clear sum/min/max/drop_cnt (FIFO and seq untouched)
//   out_valid/out_ready/out_data/out_seq : FWFT drain interface
//   level/full/empty: FIFO occupancy
//   drop_cnt        : results lost to a full FIFO, saturating
//   sum_q/min_q/max_q : statistics over every in_valid sample
// DATA_W/SEQ_W must match the widths of result_entry_t.
module result_collector
    import result_pkg::*;
#(
    parameter int  DEPTH  = 8,
    parameter int  DATA_W = DEF_DATA_W,
    parameter int  SEQ_W  = DEF_SEQ_W,
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  stats_clr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [SEQ_W-1:0]      out_seq,
    output logic [LVL_W-1:0]      level,
    output logic                  full,
    output logic                  empty,
    output logic [7:0]            drop_cnt,
    output logic [STAT_SUM_W-1:0] sum_q,
    output logic [DATA_W-1:0]     min_q,
    output logic [DATA_W-1:0]     max_q
);

    logic [SEQ_W-1:0]      seq_q, seq_d;
    logic [7:0]            drop_q, drop_d;
    logic [STAT_SUM_W-1:0] sum_d;
    logic [DATA_W-1:0]     min_d, max_d;
    result_entry_t         din, dout;
    logic                  fifo_drop;

    assign din      = '{seq: seq_q, data: in_data};
    assign out_data = dout.data;
    assign out_seq  = dout.seq;
    assign drop_cnt = drop_q;

    result_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (result_entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_req_i (in_valid),
        .din_i      (din),
        .pop_req_i  (out_ready),
        .dout_o     (dout),
        .valid_o    (out_valid),
        .level_o    (level),
        .full_o     (full),
        .empty_o    (empty),
        .drop_o     (fifo_drop)
    );

    // A clear and a sample in the same cycle: the sample lands on cleared values.
    always_comb begin
        seq_d  = seq_q + SEQ_W'(in_valid);
        sum_d  = stats_clr ? '0 : sum_q;
        min_d  = stats_clr ? '1 : min_q;
        max_d  = stats_clr ? '0 : max_q;
        drop_d = stats_clr ? '0 : drop_q;
        if (in_valid) begin
            sum_d = sum_d + STAT_SUM_W'(in_data);
            if (in_data < min_d) min_d = in_data;
            if (in_data > max_d) max_d = in_data;
        end
        if (fifo_drop && (drop_d != 8'hFF)) drop_d = drop_d + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q  <= '0;
            drop_q <= '0;
            sum_q  <= '0;
            min_q  <= '1;
            max_q  <= '0;
        end else begin
            seq_q  <= seq_d;
            drop_q <= drop_d;
            sum_q  <= sum_d;
            min_q  <= min_d;
            max_q  <= max_d;
        end
    end

endmodule

// File: tb/tb_result_collector.sv
module tb_result_collector;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        stats_clr;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [7:0]  out_seq;
    logic [3:0]  level;
    logic        full;
    logic        empty;
    logic [7:0]  drop_cnt;
    logic [15:0] sum_q;
    logic [7:0]  min_q;
    logic [7:0]  max_q;

    result_collector #(.DEPTH(8), .DATA_W(8), .SEQ_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .stats_clr (stats_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_seq   (out_seq),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .drop_cnt  (drop_cnt),
        .sum_q     (sum_q),
        .min_q     (min_q),
        .max_q     (max_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Scoreboard of expected {seq, data} in FIFO order, plus reference model.
    logic [15:0] sb[$];
    logic [7:0]  m_seq;
    int          m_drop;
    logic [15:0] m_sum;
    logic [7:0]  m_min;
    logic [7:0]  m_max;
    logic [7:0]  last_seq;
    bit          have_last;
    int          gaps;

    task automatic model_reset();
        sb.delete();
        m_seq     = 8'd0;
        m_drop    = 0;
        m_sum     = 16'd0;
        m_min     = 8'hFF;
        m_max     = 8'h00;
        have_last = 1'b0;
        gaps      = 0;
    endtask

    // One clock of stimulus; the head is scored at the negedge before a pop.
    task automatic step(input bit v, input logic [7:0] d, input bit rdy, input bit clr);
        int          cur;
        bit          pop, push, dropped;
        logic [7:0]  diff;
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        stats_clr = clr;
        cur     = sb.size();
        pop     = (cur > 0) && rdy;
        push    = v && ((cur < 8) || pop);
        dropped = v && !push;
        if (clr) begin
            m_sum  = 16'd0;
            m_min  = 8'hFF;
            m_max  = 8'h00;
            m_drop = 0;
        end
        if (v) begin
            m_sum = m_sum + {8'd0, d};
            if (d < m_min) m_min = d;
            if (d > m_max) m_max = d;
        end
        if (dropped && m_drop < 255) m_drop++;
        @(negedge clk);
        if (pop) begin
            n_total++;
            if (out_valid !== 1'b1 || {out_seq, out_data} !== sb[0])
                $display("FAIL pop_head: got valid=%b seq=%0d data=%h, want seq=%0d data=%h",
                         out_valid, out_seq, out_data, sb[0][15:8], sb[0][7:0]);
            else
                n_pass++;
            if (have_last) begin
                diff = out_seq - last_seq - 8'd1;
                gaps = gaps + int'(diff);
            end
            last_seq  = out_seq;
            have_last = 1'b1;
            void'(sb.pop_front());
        end
        if (push) sb.push_back({m_seq, d});
        if (v) m_seq = m_seq + 8'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        stats_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0);
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        model_reset();
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (level !== 4'd0) $display("FAIL rst_level: got %0d want 0", level); else n_pass++;
        n_total++; if (empty !== 1'b1) $display("FAIL rst_empty: got %b want 1", empty); else n_pass++;
        n_total++; if (full !== 1'b0) $display("FAIL rst_full: got %b want 0", full); else n_pass++;
        n_total++; if (sum_q !== 16'h0000) $display("FAIL rst_sum: got %h want 0000", sum_q); else n_pass++;
        n_total++; if (min_q !== 8'hFF) $display("FAIL rst_min: got %h want ff", min_q); else n_pass++;
        n_total++; if (max_q !== 8'h00) $display("FAIL rst_max: got %h want 00", max_q); else n_pass++;
        n_total++; if (drop_cnt !== 8'd0) $display("FAIL rst_drop: got %0d want 0", drop_cnt); else n_pass++;
    endtask

    task automatic test_push_basic();
        step(1'b1, 8'h0C, 1'b0, 1'b0);
        step(1'b1, 8'h20, 1'b0, 1'b0);
        step(1'b1, 8'h05, 1'b0, 1'b0);
        idle();
        n_total++; if (level !== 4'd3) $display("FAIL basic_level: got %0d want 3", level); else n_pass++;
        n_total++; if (out_data !== 8'h0C) $display("FAIL basic_head_data: got %h want 0c", out_data); else n_pass++;
        n_total++; if (out_seq !== 8'd0) $display("FAIL basic_head_seq: got %0d want 0", out_seq); else n_pass++;
        n_total++; if (sum_q !== 16'h0031) $display("FAIL basic_sum: got %h want 0031", sum_q); else n_pass++;
        n_total++; if (min_q !== 8'h05) $display("FAIL basic_min: got %h want 05", min_q); else n_pass++;
        n_total++; if (max_q !== 8'h20) $display("FAIL basic_max: got %h want 20", max_q); else n_pass++;
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        idle();
        n_total++; if (empty !== 1'b1) $display("FAIL basic_drained: empty=%b want 1", empty); else n_pass++;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 10; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        idle();
        n_total++; if (full !== 1'b1) $display("FAIL ovf_full: got %b want 1", full); else n_pass++;
        n_total++; if (level !== 4'd8) $display("FAIL ovf_level: got %0d want 8", level); else n_pass++;
        n_total++; if (drop_cnt !== 8'd2) $display("FAIL ovf_drop: got %0d want 2", drop_cnt); else n_pass++;
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b0);
        idle();
        n_total++; if (out_seq !== 8'd10) $display("FAIL ovf_next_seq: got %0d want 10", out_seq); else n_pass++;
        n_total++; if (out_data !== 8'h77) $display("FAIL ovf_next_data: got %h want 77", out_data); else n_pass++;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        idle();
    endtask

    task automatic test_full_simul();
        logic [7:0] d0;
        for (int i = 0; i < 8; i++) step(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
        idle();
        n_total++; if (full !== 1'b1) $display("FAIL fs_full: got %b want 1", full); else n_pass++;
        d0 = 8'(m_drop);
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        idle();
        n_total++; if (level !== 4'd8) $display("FAIL fs_level: got %0d want 8", level); else n_pass++;
        n_total++; if (drop_cnt !== d0) $display("FAIL fs_drop: got %0d want %0d", drop_cnt, d0); else n_pass++;
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        idle();
        n_total++; if (level !== 4'd1 || out_data !== 8'hAA)
            $display("FAIL fs_last: got level=%0d data=%h want level=1 data=aa", level, out_data);
        else n_pass++;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        idle();
        n_total++; if (empty !== 1'b1) $display("FAIL fs_drained: empty=%b want 1", empty); else n_pass++;
    endtask

    task automatic test_random();
        int pushes;
        do_reset();
        pushes = 0;
        for (int cyc = 0; cyc < 400 && pushes < 39; cyc++) begin
            bit v;
            v = 1'($urandom_range(0, 1));
            if (v) pushes++;
            step(v, 8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), 1'b0);
        end
        step(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
        for (int cyc = 0; cyc < 40 && sb.size() > 0; cyc++) step(1'b0, 8'h00, 1'b1, 1'b0);
        idle();
        n_total++; if (sb.size() != 0) $display("FAIL rnd_drain_timeout: %0d entries left want 0", sb.size()); else n_pass++;
        n_total++; if (empty !== 1'b1) $display("FAIL rnd_empty: got %b want 1", empty); else n_pass++;
        n_total++; if (drop_cnt !== 8'(m_drop)) $display("FAIL rnd_drop: got %0d want %0d", drop_cnt, m_drop); else n_pass++;
        n_total++; if (gaps != m_drop) $display("FAIL rnd_seq_gaps: got %0d want %0d", gaps, m_drop); else n_pass++;
        n_total++; if (sum_q !== m_sum) $display("FAIL rnd_sum: got %h want %h", sum_q, m_sum); else n_pass++;
        n_total++; if (min_q !== m_min) $display("FAIL rnd_min: got %h want %h", min_q, m_min); else n_pass++;
        n_total++; if (max_q !== m_max) $display("FAIL rnd_max: got %h want %h", max_q, m_max); else n_pass++;
    endtask

    task automatic test_stats_clr();
        for (int i = 0; i < 3; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'h40, 1'b0, 1'b1);
        idle();
        n_total++; if (sum_q !== 16'h0040) $display("FAIL clr_sum: got %h want 0040", sum_q); else n_pass++;
        n_total++; if (min_q !== 8'h40 || max_q !== 8'h40)
            $display("FAIL clr_minmax: got min=%h max=%h want 40/40", min_q, max_q);
        else n_pass++;
        n_total++; if (drop_cnt !== 8'd0) $display("FAIL clr_drop: got %0d want 0", drop_cnt); else n_pass++;
        n_total++; if (level !== 4'd4) $display("FAIL clr_level: got %0d want 4", level); else n_pass++;
        n_total++; if (out_data !== 8'h10 || out_seq !== sb[0][15:8])
            $display("FAIL clr_head: got seq=%0d data=%h want seq=%0d data=10", out_seq, out_data, sb[0][15:8]);
        else n_pass++;
        for (int i = 0; i < 4; i++) step(1'b1, 8'h50, 1'b0, 1'b0);
        step(1'b1, 8'h09, 1'b0, 1'b1);
        idle();
        n_total++; if (drop_cnt !== 8'd1) $display("FAIL clr_drop_same: got %0d want 1", drop_cnt); else n_pass++;
        n_total++; if (sum_q !== 16'h0009) $display("FAIL clr_sum_same: got %h want 0009", sum_q); else n_pass++;
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        idle();
        n_total++; if (empty !== 1'b1) $display("FAIL clr_drained: empty=%b want 1", empty); else n_pass++;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        stats_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_push_basic();
        test_overflow();
        test_full_simul();
        test_random();
        test_stats_clr();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/result_collector.md
Name: result_collector

Overview:
- Downstream consumer of the 8-bit W result stream produced by the ROM-driven ALU datapath.
- The datapath's controller asserts in_valid for one cycle each time a final W value is written, on its last ALU step of the instruction.
- Each result is buffered in a small FIFO tagged with a sequence number, drained over a valid/ready interface, and tracked by running stream statistics (sum, min, max, drops).

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- DATA_W, 8, result width; matches W.
- SEQ_W, 8, sequence-tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high, sampled on the rising edge of clk.
- in_valid  in  1  one-cycle strobe: in_data is a new result.
- in_data  in  DATA_W  result value.
- stats_clr  in  1  synchronous clear of the statistics outputs.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head.
- out_data  out  DATA_W  FIFO head data.
- out_seq  out  SEQ_W  sequence tag of the head entry.
- level  out  $clog2(DEPTH)+1  current occupancy.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- drop_cnt  out  8  count of results lost to a full FIFO; saturates at 255.
- sum_q  out  16  wrapping sum of all in_data (mod 2^16).
- min_q  out  DATA_W  minimum in_data since reset/clear.
- max_q  out  DATA_W  maximum in_data since reset/clear.

Behaviour:
- Reset (rst=1 at a clock edge) dominates everything, including mid-transfer.
  - Post-reset values: FIFO empty, pointers 0, level=0, empty=1, full=0, out_valid=0, seq counter 0, drop_cnt=0, sum_q=0, min_q=all ones, max_q=0.
  - out_data and out_seq are don't-care while out_valid=0.
- FIFO is first-word-fall-through:
  - out_valid = !empty.
  - out_data/out_seq come combinationally from storage at rd_ptr.
  - A written entry is visible at the head the cycle after the write edge (1-cycle latency into an empty FIFO).
- Pop: out_valid && out_ready at the edge. rd_ptr increments and wraps mod DEPTH.
- Push: in_valid && (!full || pop). wr_ptr increments and wraps mod DEPTH. The entry stores {seq counter, in_data}.
- Simultaneous push and pop:
  - Both happen and level is unchanged.
  - When full, the push is accepted, not dropped.
  - When empty, no pop occurs (out_valid=0); the push proceeds normally.
- Drop: in_valid && full && !pop. Data is discarded and drop_cnt increments, saturating at 255.
- Sequence counter:
  - Increments on every in_valid, accepted or dropped, and wraps at 2^SEQ_W.
  - Dropped results therefore appear as gaps in out_seq.
- Statistics update on every in_valid, regardless of FIFO acceptance:
  - sum_q += zero-extended in_data, mod 2^16.
  - min_q = min(min_q, in_data), unsigned.
  - max_q = max(max_q, in_data), unsigned.
- stats_clr:
  - Sets sum_q, min_q, max_q and drop_cnt to their reset values.
  - Does not touch the FIFO or the seq counter.
  - With in_valid in the same cycle, the sample is applied on top of the cleared values: sum_q=in_data, min_q=max_q=in_data, drop_cnt=0.
  - If that sample is also dropped, drop_cnt=1.
- All outputs except out_data/out_seq are registered or derived from registered level only.
- in_valid is not required to be 1-in-3. Back-to-back strobes every cycle must be handled.

Decomposition:
- Shared package result_pkg:
  - Defines DATA_W/SEQ_W defaults.
  - Defines typedef result_entry_t {logic [SEQ_W-1:0] seq; logic [DATA_W-1:0] data;}.
  - Defines STAT_SUM_W=16.
- Sub-module result_fifo holds storage, pointers, level, full/empty and push/pop arbitration, parameterised by DEPTH and entry type.
- Statistics, drop counter and seq counter live in result_collector.

Test Plan:
- Reset: assert rst 2 cycles mid-burst -> out_valid=0, level=0, empty=1, sum_q=0x0000, min_q=0xFF, max_q=0x00, drop_cnt=0.
- Push 0x0C, 0x20, 0x05 with out_ready=0:
  - level=3, out_data=0x0C, out_seq=0.
  - sum_q=0x0031, min_q=0x05, max_q=0x20.
- 10 back-to-back pushes of 1..10 with out_ready=0:
  - full=1 and drop_cnt=2.
  - Draining yields data 1..8 with seq 0..7.
  - The next push gets seq 10.
- At full (level=8), in_valid=1 and out_ready=1 in the same cycle -> level stays 8, drop_cnt unchanged, new entry is delivered last.
- 40 random pushes with random out_ready -> in-order data, pointer wrap verified, seq gaps exactly equal the drop_cnt increments.
- stats_clr=1 with in_valid=1, in_data=0x40 -> sum_q=0x0040, min_q=max_q=0x40, drop_cnt=0; FIFO contents and level unchanged.
